mat_mul_axil_ctrl: RTL

//   AXI-Lite slave register block directly upstream of mat_mul. It drives mat_mul's
//   sel (level) and start (1-cycle pulse) inputs. It snoops the input and result
//   AXI-Stream handshakes to report busy/done status and beat counts to ARM software.
//   It replaces ad-hoc sel/start wiring from the generic AXI-Lite slave port.

---
 rtl/mat_mul_pkg.sv | 30 +++
 rtl/beat_counter.sv | 27 ++
 rtl/mat_mul_axil_ctrl.sv | 219 +++++++++++++++++++++
 3 files changed

// File: rtl/mat_mul_pkg.sv
// Shared definitions for the mat_mul control block: register map, bit positions,
// response codes and the one-hot status FSM encoding.
package mat_mul_pkg;

  localparam logic [1:0] REG_CTRL    = 2'd0;
  localparam logic [1:0] REG_STATUS  = 2'd1;
  localparam logic [1:0] REG_IN_CNT  = 2'd2;
  localparam logic [1:0] REG_OUT_CNT = 2'd3;

  localparam int CTRL_SEL_BIT   = 0;
  localparam int CTRL_START_BIT = 1;

  localparam int STAT_BUSY_BIT = 0;
  localparam int STAT_DONE_BIT = 1;
  localparam int STAT_DROP_BIT = 2;

  localparam logic [1:0] RESP_OKAY = 2'b00;

  typedef enum logic [2:0] {
    S_IDLE = 3'b001,
    S_RUN  = 3'b010,
    S_DONE = 3'b100
  } state_t;

  // Word index of a byte address in the 16-byte register window.
  function automatic logic [1:0] reg_index(input logic [3:0] addr);
    return addr[3:2];
  endfunction

endpackage

// File: rtl/beat_counter.sv
// Free-running stream beat counter with synchronous clear; a beat arriving in
// the clearing cycle is still counted, so the count restarts at one.
module beat_counter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc,
  input  logic             clear,
  output logic [WIDTH-1:0] count
);

  logic [WIDTH-1:0] count_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_reg <= '0;
    end else if (clear) begin
      count_reg <= {{(WIDTH-1){1'b0}}, inc};
    end else if (inc) begin
      count_reg <= count_reg + 1'b1;
    end
  end

  assign count = count_reg;

endmodule

// File: rtl/mat_mul_axil_ctrl.sv
// AXI-Lite register block driving mat_mul sel/start and reporting run status
// and stream beat counts gathered by snooping the mat_mul AXI-Stream ports.
module mat_mul_axil_ctrl
  import mat_mul_pkg::*;
#(
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int C_S_AXI_ADDR_WIDTH = 4,
  parameter int DIM_LOG            = 1
) (
  input  logic                            s00_axi_aclk,
  input  logic                            s00_axi_aresetn,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   s00_axi_awaddr,
  input  logic [2:0]                      s00_axi_awprot,
  input  logic                            s00_axi_awvalid,
  output logic                            s00_axi_awready,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]   s00_axi_wdata,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0] s00_axi_wstrb,
  input  logic                            s00_axi_wvalid,
  output logic                            s00_axi_wready,
  output logic [1:0]                      s00_axi_bresp,
  output logic                            s00_axi_bvalid,
  input  logic                            s00_axi_bready,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   s00_axi_araddr,
  input  logic [2:0]                      s00_axi_arprot,
  input  logic                            s00_axi_arvalid,
  output logic                            s00_axi_arready,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   s00_axi_rdata,
  output logic [1:0]                      s00_axi_rresp,
  output logic                            s00_axi_rvalid,
  input  logic                            s00_axi_rready,
  output logic                            sel,
  output logic                            start,
  input  logic                            in_tvalid,
  input  logic                            in_tready,
  input  logic                            in_tlast,
  input  logic                            res_tvalid,
  input  logic                            res_tready,
  input  logic                            res_tlast
);

  logic                          live_reg;
  logic                          aw_full_reg;
  logic [1:0]                    aw_idx_reg;
  logic                          w_full_reg;
  logic [2:0]                    w_bits_reg;
  logic                          w_strb0_reg;
  logic                          bvalid_reg;
  logic                          rvalid_reg;
  logic [C_S_AXI_DATA_WIDTH-1:0] rdata_reg;
  logic                          sel_reg;
  logic                          start_reg;
  logic                          drop_reg;
  state_t                        state_reg;
  state_t                        state_next;

  logic                          aw_hs, w_hs, ar_hs, commit;
  logic                          wr_ctrl, wr_status;
  logic                          start_req, start_fire, start_drop;
  logic                          done_clear, drop_clear;
  logic                          in_beat, res_beat, res_last;
  logic                          busy, done;
  logic [31:0]                   in_count, out_count;
  logic [C_S_AXI_DATA_WIDTH-1:0] rd_word;

  // Ready outputs stay low until the first clock after reset release.
  assign s00_axi_awready = live_reg & ~aw_full_reg & ~bvalid_reg;
  assign s00_axi_wready  = live_reg & ~w_full_reg & ~bvalid_reg;
  assign s00_axi_arready = live_reg & ~rvalid_reg;

  assign aw_hs  = s00_axi_awvalid & s00_axi_awready;
  assign w_hs   = s00_axi_wvalid & s00_axi_wready;
  assign ar_hs  = s00_axi_arvalid & s00_axi_arready;
  assign commit = aw_full_reg & w_full_reg;

  assign wr_ctrl    = commit & w_strb0_reg & (aw_idx_reg == REG_CTRL);
  assign wr_status  = commit & w_strb0_reg & (aw_idx_reg == REG_STATUS);
  assign start_req  = wr_ctrl & w_bits_reg[CTRL_START_BIT];
  assign start_fire = start_req & (state_reg != S_RUN);
  assign start_drop = start_req & (state_reg == S_RUN);
  assign done_clear = wr_status & w_bits_reg[STAT_DONE_BIT];
  assign drop_clear = wr_status & w_bits_reg[STAT_DROP_BIT];

  assign in_beat  = in_tvalid & in_tready;
  assign res_beat = res_tvalid & res_tready;
  assign res_last = res_beat & res_tlast;

  assign busy = (state_reg == S_RUN);
  assign done = (state_reg == S_DONE);

  always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
    if (!s00_axi_aresetn) begin
      live_reg    <= 1'b0;
      aw_full_reg <= 1'b0;
      aw_idx_reg  <= '0;
      w_full_reg  <= 1'b0;
      w_bits_reg  <= '0;
      w_strb0_reg <= 1'b0;
      bvalid_reg  <= 1'b0;
      rvalid_reg  <= 1'b0;
      rdata_reg   <= '0;
      sel_reg     <= 1'b0;
      start_reg   <= 1'b0;
      drop_reg    <= 1'b0;
    end else begin
      live_reg <= 1'b1;

      if (aw_hs) begin
        aw_full_reg <= 1'b1;
        aw_idx_reg  <= reg_index(s00_axi_awaddr);
      end else if (commit) begin
        aw_full_reg <= 1'b0;
      end

      if (w_hs) begin
        w_full_reg  <= 1'b1;
        w_bits_reg  <= s00_axi_wdata[2:0];
        w_strb0_reg <= s00_axi_wstrb[0];
      end else if (commit) begin
        w_full_reg <= 1'b0;
      end

      if (commit) begin
        bvalid_reg <= 1'b1;
      end else if (bvalid_reg && s00_axi_bready) begin
        bvalid_reg <= 1'b0;
      end

      if (wr_ctrl) begin
        sel_reg <= w_bits_reg[CTRL_SEL_BIT];
      end
      start_reg <= start_fire;

      if (start_drop) begin
        drop_reg <= 1'b1;
      end else if (drop_clear) begin
        drop_reg <= 1'b0;
      end

      // rdata is captured once per read and held until the R handshake.
      if (ar_hs) begin
        rvalid_reg <= 1'b1;
        rdata_reg  <= rd_word;
      end else if (rvalid_reg && s00_axi_rready) begin
        rvalid_reg <= 1'b0;
      end
    end
  end

  always_comb begin
    rd_word = '0;
    case (reg_index(s00_axi_araddr))
      REG_CTRL: begin
        rd_word[CTRL_SEL_BIT] = sel_reg;
      end
      REG_STATUS: begin
        rd_word[STAT_BUSY_BIT] = busy;
        rd_word[STAT_DONE_BIT] = done;
        rd_word[STAT_DROP_BIT] = drop_reg;
      end
      REG_IN_CNT:  rd_word = in_count;
      REG_OUT_CNT: rd_word = out_count;
    endcase
  end

  always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
    if (!s00_axi_aresetn) begin
      state_reg <= S_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // A final result beat landing with the done clear keeps the block in S_DONE.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_IDLE: if (start_fire) state_next = S_RUN;
      S_RUN:  if (res_last) state_next = S_DONE;
      S_DONE: begin
        if (start_fire) begin
          state_next = S_RUN;
        end else if (done_clear && !res_last) begin
          state_next = S_IDLE;
        end
      end
      default: state_next = S_IDLE;
    endcase
  end

  beat_counter #(.WIDTH(32)) u_in_cnt (
    .clk   (s00_axi_aclk),
    .rst_n (s00_axi_aresetn),
    .inc   (in_beat),
    .clear (done_clear),
    .count (in_count)
  );

  beat_counter #(.WIDTH(32)) u_out_cnt (
    .clk   (s00_axi_aclk),
    .rst_n (s00_axi_aresetn),
    .inc   (res_beat),
    .clear (done_clear),
    .count (out_count)
  );

  assign s00_axi_bvalid = bvalid_reg;
  assign s00_axi_bresp  = RESP_OKAY;
  assign s00_axi_rvalid = rvalid_reg;
  assign s00_axi_rdata  = rdata_reg;
  assign s00_axi_rresp  = RESP_OKAY;
  assign sel            = sel_reg;
  assign start          = start_reg;

  logic unused_ok;
  assign unused_ok = ^{s00_axi_awprot, s00_axi_arprot, in_tlast,
                       s00_axi_wdata[C_S_AXI_DATA_WIDTH-1:3],
                       s00_axi_wstrb[C_S_AXI_DATA_WIDTH/8-1:1], DIM_LOG[0]};

endmodule
